instruction_encoder_loader: RTL

//  Inverse of the immediate generator: packs instruction fields (format, regs, functs, imm) into 32-bit
//  RV32 instruction words and streams them into instruction memory at incrementing addresses.

---
 rtl/instruction_encoder_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder_loader.sv
// instruction_encoder_loader
// Packs RV32 instruction fields into 32-bit words and streams them into
// instruction memory at incrementing word addresses. Each bundle takes three
// cycles: capture (IDLE), encode + range check (ENC), memory write (WR).
//
// Handshake: a bundle transfers on a rising edge where in_valid and in_ready
// are both high; the source must hold the bundle stable until that edge.
// in_ready is high only in IDLE while neither full nor done.
module instruction_encoder_loader #(
  parameter int Width     = 32,
  parameter int AddrWidth = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [Width-1:0]     imm,
  input  logic                 last,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [Width-1:0]     mem_wdata,
  output logic [AddrWidth:0]   count,
  output logic                 full,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2
  } state_e;

  localparam logic [AddrWidth:0] FullCount = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0] CountOne  = {{AddrWidth{1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [2:0]           fmt_q;
  logic [4:0]           rd_q, rs1_q, rs2_q;
  logic [2:0]           f3_q;
  logic [6:0]           f7_q;
  logic [Width-1:0]     imm_q;
  logic                 last_q;
  logic [Width-1:0]     word_q;
  logic [AddrWidth:0]   count_q;
  logic                 done_q, err_q;

  logic                 accept;
  logic [Width-1:0]     enc_word;
  logic                 enc_err;
  logic                 imm12_ok, imm20_ok;

  assign full      = (count_q == FullCount);
  assign in_ready  = (state_q == IDLE) & ~full & ~done_q;
  assign accept    = in_valid & in_ready;
  assign mem_we    = (state_q == WR);
  assign mem_addr  = count_q[AddrWidth-1:0];
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign done      = done_q;
  assign err       = err_q;
  assign dbg_state = state_q;

  // Immediate must survive the decoder's sign extension unchanged.
  assign imm12_ok = (imm_q == {{(Width-12){imm_q[11]}}, imm_q[11:0]});
  assign imm20_ok = (imm_q == {{(Width-20){imm_q[19]}}, imm_q[19:0]});

  // Field packing per format; bit placement is the exact inverse of the core decoder.
  always_comb begin
    enc_word = '0;
    enc_err  = 1'b0;
    case (fmt_q)
      3'd0: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, 7'b0110011};
      3'd1: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0000011};
        enc_err  = ~imm12_ok;
      end
      3'd2: begin
        enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], 7'b0100011};
        enc_err  = ~imm12_ok;
      end
      3'd3: begin
        enc_word = {imm_q[11], imm_q[9:4], rs2_q, rs1_q, f3_q, imm_q[3:0], imm_q[10], 7'b1100011};
        enc_err  = ~imm12_ok;
      end
      3'd4: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b0010011};
        enc_err  = ~imm12_ok;
      end
      3'd5: begin
        enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, 7'b1100111};
        enc_err  = ~imm12_ok;
      end
      3'd6: begin
        enc_word = {imm_q[19], imm_q[9:0], imm_q[10], imm_q[18:11], rd_q, 7'b1101111};
        enc_err  = ~imm20_ok;
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Next-state: IDLE -> ENC on accept, ENC -> WR (or back to IDLE on error), WR -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ENC;
      ENC:     state_d = enc_err ? IDLE : WR;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, field capture, encoded word, write counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      fmt_q   <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      imm_q   <= '0;
      last_q  <= 1'b0;
      word_q  <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        fmt_q  <= fmt;
        rd_q   <= rd;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        f3_q   <= funct3;
        f7_q   <= funct7;
        imm_q  <= imm;
        last_q <= last;
      end
      if (state_q == ENC) begin
        if (enc_err) begin
          err_q <= 1'b1;
          if (last_q) done_q <= 1'b1;
        end else begin
          word_q <= enc_word;
        end
      end
      if (state_q == WR) begin
        count_q <= count_q + CountOne;
        if (last_q) done_q <= 1'b1;
      end
    end
  end

endmodule
